// File: rtl/register_file.sv
// register_file: architectural registers with rename busy/tag status, commit bypass and flush
module register_file #(
    parameter int ROB_TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic [4:0]           in_decode_tag1,
    output logic [31:0]          out_decode_value1,
    output logic [ROB_TAG_W-1:0] out_decode_robtag1,
    output logic                 out_decode_busy1,
    input  logic [4:0]           in_decode_tag2,
    output logic [31:0]          out_decode_value2,
    output logic [ROB_TAG_W-1:0] out_decode_robtag2,
    output logic                 out_decode_busy2,
    input  logic [4:0]           in_decode_destination,
    input  logic [ROB_TAG_W-1:0] in_decode_rob_tag,
    input  logic [4:0]           in_rob_commit_destination,
    input  logic [31:0]          in_rob_commit_value,
    input  logic [ROB_TAG_W-1:0] in_rob_commit_tag,
    input  logic                 in_rob_misbranch
);
    localparam int RW = 33 + ROB_TAG_W;

    logic [31:0]          r_value [1:31];
    logic [ROB_TAG_W-1:0] r_tag   [1:31];
    logic [31:1]          r_busy;
    logic [RW-1:0]        w_rd1;
    logic [RW-1:0]        w_rd2;
    logic                 w_commit;
    logic                 w_issue;

    assign w_commit = in_rob_commit_destination != 5'd0;
    assign w_issue  = !in_rob_misbranch && in_decode_destination != 5'd0 && in_decode_rob_tag != '0;

    // Returns {busy, robtag, value}; x0 reads as zero and a matching commit is forwarded
    function automatic logic [RW-1:0] read_reg(input logic [4:0] idx);
        logic [RW-1:0] res;
        res = '0;
        if (idx != 5'd0) begin
            if (r_busy[idx] && w_commit && in_rob_commit_destination == idx && in_rob_commit_tag == r_tag[idx])
                res = {1'b0, {ROB_TAG_W{1'b0}}, in_rob_commit_value};
            else
                res = {r_busy[idx], r_busy[idx] ? r_tag[idx] : {ROB_TAG_W{1'b0}}, r_value[idx]};
        end
        return res;
    endfunction

    // Two independent combinational source-operand reads
    always_comb begin
        w_rd1 = read_reg(in_decode_tag1);
        w_rd2 = read_reg(in_decode_tag2);
    end

    assign {out_decode_busy1, out_decode_robtag1, out_decode_value1} = w_rd1;
    assign {out_decode_busy2, out_decode_robtag2, out_decode_value2} = w_rd2;

    // State update: flush clears rename, commit retires, issue renames last so a newer producer wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            for (int i = 1; i < 32; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
        end else if (rdy) begin
            if (in_rob_misbranch) begin
                r_busy <= '0;
                for (int i = 1; i < 32; i++) r_tag[i] <= '0;
            end
            if (w_commit) begin
                r_value[in_rob_commit_destination] <= in_rob_commit_value;
                if (r_busy[in_rob_commit_destination] && r_tag[in_rob_commit_destination] == in_rob_commit_tag) begin
                    r_busy[in_rob_commit_destination] <= 1'b0;
                    r_tag[in_rob_commit_destination]  <= '0;
                end
            end
            if (w_issue) begin
                r_busy[in_decode_destination] <= 1'b1;
                r_tag[in_decode_destination]  <= in_decode_rob_tag;
            end
        end
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and randomized checks of register_file against a reference model
module tb_register_file;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst, rdy, in_rob_misbranch;
    logic [4:0]    in_decode_tag1, in_decode_tag2, in_decode_destination, in_rob_commit_destination;
    logic [TW-1:0] in_decode_rob_tag, in_rob_commit_tag;
    logic [31:0]   in_rob_commit_value;
    logic [31:0]   out_decode_value1, out_decode_value2;
    logic [TW-1:0] out_decode_robtag1, out_decode_robtag2;
    logic          out_decode_busy1, out_decode_busy2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]   m_value [32];
    logic          m_busy  [32];
    logic [TW-1:0] m_tag   [32];

    register_file #(.ROB_TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_decode_tag1(in_decode_tag1), .out_decode_value1(out_decode_value1),
        .out_decode_robtag1(out_decode_robtag1), .out_decode_busy1(out_decode_busy1),
        .in_decode_tag2(in_decode_tag2), .out_decode_value2(out_decode_value2),
        .out_decode_robtag2(out_decode_robtag2), .out_decode_busy2(out_decode_busy2),
        .in_decode_destination(in_decode_destination), .in_decode_rob_tag(in_decode_rob_tag),
        .in_rob_commit_destination(in_rob_commit_destination), .in_rob_commit_value(in_rob_commit_value),
        .in_rob_commit_tag(in_rob_commit_tag), .in_rob_misbranch(in_rob_misbranch)
    );

    always #5 clk = ~clk;

    function automatic logic [32+TW:0] exp_read(input logic [4:0] idx);
        if (idx == 0) return '0;
        if (m_busy[idx] && in_rob_commit_destination == idx && in_rob_commit_tag == m_tag[idx])
            return {1'b0, {TW{1'b0}}, in_rob_commit_value};
        return {m_busy[idx], m_busy[idx] ? m_tag[idx] : {TW{1'b0}}, m_value[idx]};
    endfunction

    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_value[i] = 0;
                m_busy[i]  = 0;
                m_tag[i]   = 0;
            end
        end else if (rdy) begin
            if (in_rob_misbranch)
                for (int i = 0; i < 32; i++) begin
                    m_busy[i] = 0;
                    m_tag[i]  = 0;
                end
            if (in_rob_commit_destination != 0) begin
                m_value[in_rob_commit_destination] = in_rob_commit_value;
                if (m_busy[in_rob_commit_destination] && m_tag[in_rob_commit_destination] == in_rob_commit_tag) begin
                    m_busy[in_rob_commit_destination] = 0;
                    m_tag[in_rob_commit_destination]  = 0;
                end
            end
            if (!in_rob_misbranch && in_decode_destination != 0 && in_decode_rob_tag != 0) begin
                m_busy[in_decode_destination] = 1;
                m_tag[in_decode_destination]  = in_decode_rob_tag;
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; rdy = 1; in_rob_misbranch = 0;
        in_decode_tag1 = 0; in_decode_tag2 = 0;
        in_decode_destination = 0; in_decode_rob_tag = 0;
        in_rob_commit_destination = 0; in_rob_commit_value = 0; in_rob_commit_tag = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick();
        tick();
        idle();
        in_decode_tag1 = 5; in_decode_tag2 = 0;
        #1;
        n_checks++;
        if ({out_decode_busy1, out_decode_robtag1, out_decode_value1} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_x5 got %h want 0", {out_decode_busy1, out_decode_robtag1, out_decode_value1});
        end
        n_checks++;
        if ({out_decode_busy2, out_decode_robtag2, out_decode_value2} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_x0 got %h want 0", {out_decode_busy2, out_decode_robtag2, out_decode_value2});
        end
    endtask

    task automatic test_issue_commit();
        idle();
        in_decode_destination = 5; in_decode_rob_tag = 3;
        tick();
        idle();
        in_decode_tag1 = 5;
        #1;
        n_checks++;
        if ({out_decode_busy1, out_decode_robtag1, out_decode_value1} !== {1'b1, 4'd3, 32'd0}) begin
            n_fail++;
            $display("FAIL issue_x5 got %h want %h", {out_decode_busy1, out_decode_robtag1, out_decode_value1}, {1'b1, 4'd3, 32'd0});
        end
        in_rob_commit_destination = 5; in_rob_commit_tag = 3; in_rob_commit_value = 32'h1234;
        #1;
        n_checks++;
        if ({out_decode_busy1, out_decode_robtag1, out_decode_value1} !== {1'b0, 4'd0, 32'h1234}) begin
            n_fail++;
            $display("FAIL bypass_x5 got %h want %h", {out_decode_busy1, out_decode_robtag1, out_decode_value1}, {1'b0, 4'd0, 32'h1234});
        end
        tick();
        idle();
        in_decode_tag2 = 5;
        #1;
        n_checks++;
        if ({out_decode_busy2, out_decode_robtag2, out_decode_value2} !== {1'b0, 4'd0, 32'h1234}) begin
            n_fail++;
            $display("FAIL commit_x5 got %h want %h", {out_decode_busy2, out_decode_robtag2, out_decode_value2}, {1'b0, 4'd0, 32'h1234});
        end
    endtask

    task automatic test_stale_commit();
        idle();
        in_decode_destination = 7; in_decode_rob_tag = 2;
        tick();
        in_decode_rob_tag = 4;
        tick();
        idle();
        in_rob_commit_destination = 7; in_rob_commit_tag = 2; in_rob_commit_value = 9;
        in_decode_tag1 = 7;
        #1;
        n_checks++;
        if ({out_decode_busy1, out_decode_robtag1, out_decode_value1} !== {1'b1, 4'd4, 32'd0}) begin
            n_fail++;
            $display("FAIL stale_nobypass got %h want %h", {out_decode_busy1, out_decode_robtag1, out_decode_value1}, {1'b1, 4'd4, 32'd0});
        end
        tick();
        idle();
        in_decode_tag1 = 7;
        #1;
        n_checks++;
        if ({out_decode_busy1, out_decode_robtag1, out_decode_value1} !== {1'b1, 4'd4, 32'd9}) begin
            n_fail++;
            $display("FAIL stale_commit got %h want %h", {out_decode_busy1, out_decode_robtag1, out_decode_value1}, {1'b1, 4'd4, 32'd9});
        end
    endtask

    task automatic test_same_cycle();
        idle();
        in_decode_destination = 9; in_decode_rob_tag = 1;
        tick();
        idle();
        in_rob_commit_destination = 9; in_rob_commit_tag = 1; in_rob_commit_value = 32'hAA;
        in_decode_destination = 9; in_decode_rob_tag = 5;
        tick();
        idle();
        in_decode_tag2 = 9;
        #1;
        n_checks++;
        if ({out_decode_busy2, out_decode_robtag2, out_decode_value2} !== {1'b1, 4'd5, 32'hAA}) begin
            n_fail++;
            $display("FAIL same_cycle got %h want %h", {out_decode_busy2, out_decode_robtag2, out_decode_value2}, {1'b1, 4'd5, 32'hAA});
        end
    endtask

    task automatic test_misbranch();
        idle();
        in_decode_destination = 3; in_decode_rob_tag = 6;
        tick();
        in_decode_destination = 4; in_decode_rob_tag = 7;
        tick();
        idle();
        in_rob_misbranch = 1;
        in_rob_commit_destination = 3; in_rob_commit_tag = 6; in_rob_commit_value = 32'h55;
        in_decode_destination = 8; in_decode_rob_tag = 2;
        tick();
        idle();
        in_decode_tag1 = 3; in_decode_tag2 = 4;
        #1;
        n_checks++;
        if ({out_decode_busy1, out_decode_robtag1, out_decode_value1} !== {1'b0, 4'd0, 32'h55}) begin
            n_fail++;
            $display("FAIL flush_x3 got %h want %h", {out_decode_busy1, out_decode_robtag1, out_decode_value1}, {1'b0, 4'd0, 32'h55});
        end
        n_checks++;
        if ({out_decode_busy2, out_decode_robtag2, out_decode_value2} !== 37'd0) begin
            n_fail++;
            $display("FAIL flush_x4 got %h want 0", {out_decode_busy2, out_decode_robtag2, out_decode_value2});
        end
        in_decode_tag1 = 8;
        #1;
        n_checks++;
        if ({out_decode_busy1, out_decode_robtag1, out_decode_value1} !== 37'd0) begin
            n_fail++;
            $display("FAIL flush_x8 got %h want 0", {out_decode_busy1, out_decode_robtag1, out_decode_value1});
        end
    endtask

    task automatic test_x0_rdy();
        idle();
        in_decode_destination = 0; in_decode_rob_tag = 3;
        in_rob_commit_destination = 0; in_rob_commit_value = 32'hFF;
        in_decode_tag1 = 0;
        #1;
        n_checks++;
        if ({out_decode_busy1, out_decode_robtag1, out_decode_value1} !== 37'd0) begin
            n_fail++;
            $display("FAIL x0_live got %h want 0", {out_decode_busy1, out_decode_robtag1, out_decode_value1});
        end
        tick();
        idle();
        in_decode_tag1 = 0;
        #1;
        n_checks++;
        if ({out_decode_busy1, out_decode_robtag1, out_decode_value1} !== 37'd0) begin
            n_fail++;
            $display("FAIL x0_after got %h want 0", {out_decode_busy1, out_decode_robtag1, out_decode_value1});
        end
        rdy = 0;
        in_decode_destination = 2; in_decode_rob_tag = 3;
        in_rob_commit_destination = 2; in_rob_commit_value = 32'h77;
        in_decode_tag2 = 5;
        #1;
        n_checks++;
        if ({out_decode_busy2, out_decode_robtag2, out_decode_value2} !== {1'b0, 4'd0, 32'h1234}) begin
            n_fail++;
            $display("FAIL rdy_read_live got %h want %h", {out_decode_busy2, out_decode_robtag2, out_decode_value2}, {1'b0, 4'd0, 32'h1234});
        end
        tick();
        idle();
        in_decode_tag1 = 2;
        #1;
        n_checks++;
        if ({out_decode_busy1, out_decode_robtag1, out_decode_value1} !== 37'd0) begin
            n_fail++;
            $display("FAIL rdy_frozen got %h want 0", {out_decode_busy1, out_decode_robtag1, out_decode_value1});
        end
    endtask

    task automatic test_random();
        logic [36:0] e1, e2;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            rdy = ($urandom_range(0, 9) != 0);
            in_rob_misbranch = ($urandom_range(0, 19) == 0);
            in_decode_tag1 = 5'($urandom_range(0, 7));
            in_decode_tag2 = 5'($urandom_range(0, 7));
            in_decode_destination = 5'($urandom_range(0, 7));
            in_decode_rob_tag = TW'($urandom);
            in_rob_commit_destination = 5'($urandom_range(0, 7));
            in_rob_commit_value = $urandom;
            in_rob_commit_tag = $urandom_range(0, 1) ? m_tag[in_rob_commit_destination] : TW'($urandom);
            #1;
            e1 = exp_read(in_decode_tag1);
            e2 = exp_read(in_decode_tag2);
            n_checks++;
            if ({out_decode_busy1, out_decode_robtag1, out_decode_value1} !== e1) begin
                n_fail++;
                $display("FAIL rand_port1 cyc %0d idx %0d got %h want %h", c, in_decode_tag1, {out_decode_busy1, out_decode_robtag1, out_decode_value1}, e1);
            end
            n_checks++;
            if ({out_decode_busy2, out_decode_robtag2, out_decode_value2} !== e2) begin
                n_fail++;
                $display("FAIL rand_port2 cyc %0d idx %0d got %h want %h", c, in_decode_tag2, {out_decode_busy2, out_decode_robtag2, out_decode_value2}, e2);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_issue_commit();
        test_stale_commit();
        test_same_cycle();
        test_misbranch();
        test_x0_rdy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
